// File: rtl/mem_256_x16.sv
// mem_256_x16: single-port 256 x 16 synchronous RAM.
// This is the combined program and data memory for the 16-bit RISC core.
// Reads and writes both complete on the rising CLK edge, and RDATA is registered.
// Reset clears RDATA asynchronously, but it leaves the storage array untouched.
// Optional macro MEM_256X16_WRITE_THROUGH_EN:
//    defined   -> write-first: a write also drives WDATA onto RDATA.
//    undefined -> read-first (default): a write returns the old word on RDATA.
module mem_256_x16 #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             WE,
   input  logic [7:0]       ADDR,
   input  logic [WIDTH-1:0] WDATA,
   output logic [WIDTH-1:0] RDATA
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] rdata_d;

   // Storage is deliberately not reset, so contents survive RST_N.
   // A write is dropped on any edge where reset is still held.
   always_ff @(posedge CLK) begin
      if (WE && RST_N) begin
         mem_q[ADDR] <= WDATA;
      end
   end

   // Select the read-data source for this edge.
   // The only difference between the two modes is what a write returns.
   always_comb begin
      rdata_d = mem_q[ADDR];
`ifdef MEM_256X16_WRITE_THROUGH_EN
      if (WE) begin
         rdata_d = WDATA;
      end
`endif
   end

   // Registered read port, cleared as soon as reset is asserted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign RDATA = rdata_q;

endmodule

// File: tb/tb_mem_256_x16.sv
// Directed self-checking bench for mem_256_x16.
// Inputs are driven on the falling edge, and RDATA is sampled 1 ns after the rising edge.
module tb_mem_256_x16;

   logic        CLK;
   logic        RST_N;
   logic        WE;
   logic [7:0]  ADDR;
   logic [15:0] WDATA;
   logic [15:0] RDATA;

   int checks = 0;
   int errors = 0;

   mem_256_x16 dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .WE    (WE),
      .ADDR  (ADDR),
      .WDATA (WDATA),
      .RDATA (RDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one operation at the falling edge and return 1 ns after the following rising edge.
   task automatic drive_cycle(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
      @(negedge CLK);
      WE    = we;
      ADDR  = addr;
      WDATA = wdata;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      drive_cycle(1'b0, 8'h00, 16'h0000);
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (RDATA !== 16'h0000) begin
         $display("FAIL reset_async_assert: got %h expected %h", RDATA, 16'h0000);
         errors++;
      end
      @(negedge CLK);
      RST_N = 1'b1;
      #4;
      checks++;
      if (RDATA !== 16'h0000) begin
         $display("FAIL reset_hold_until_edge: got %h expected %h", RDATA, 16'h0000);
         errors++;
      end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 256; i++) begin
         drive_cycle(1'b1, 8'(i), 16'(i));
      end
      for (int i = 0; i < 256; i++) begin
         drive_cycle(1'b0, 8'(i), 16'hDEAD);
         checks++;
         if (RDATA !== 16'(i)) begin
            $display("FAIL sweep_read addr=%0h: got %h expected %h", i, RDATA, 16'(i));
            errors++;
         end
      end
   endtask

   task automatic test_write_inhibit();
      drive_cycle(1'b0, 8'h10, 16'hBEEF);
      checks++;
      if (RDATA !== 16'h0010) begin
         $display("FAIL inhibit_same_edge: got %h expected %h", RDATA, 16'h0010);
         errors++;
      end
      drive_cycle(1'b0, 8'h10, 16'h0000);
      checks++;
      if (RDATA !== 16'h0010) begin
         $display("FAIL inhibit_readback: got %h expected %h", RDATA, 16'h0010);
         errors++;
      end
   endtask

   task automatic test_read_during_write();
      logic [15:0] exp_rdw;
`ifdef MEM_256X16_WRITE_THROUGH_EN
      exp_rdw = 16'hA5A5;
`else
      exp_rdw = 16'h0020;
`endif
      drive_cycle(1'b1, 8'h20, 16'hA5A5);
      checks++;
      if (RDATA !== exp_rdw) begin
         $display("FAIL rdw_same_edge: got %h expected %h", RDATA, exp_rdw);
         errors++;
      end
      drive_cycle(1'b0, 8'h20, 16'h0000);
      checks++;
      if (RDATA !== 16'hA5A5) begin
         $display("FAIL rdw_readback: got %h expected %h", RDATA, 16'hA5A5);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_b2b;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 8'(8'h40 + i), 16'(16'hC000 + i));
`ifdef MEM_256X16_WRITE_THROUGH_EN
         exp_b2b = 16'(16'hC000 + i);
`else
         exp_b2b = 16'(16'h0040 + i);
`endif
         checks++;
         if (RDATA !== exp_b2b) begin
            $display("FAIL b2b_write_edge i=%0d: got %h expected %h", i, RDATA, exp_b2b);
            errors++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b0, 8'(8'h40 + i), 16'h0000);
         checks++;
         if (RDATA !== 16'(16'hC000 + i)) begin
            $display("FAIL b2b_readback i=%0d: got %h expected %h", i, RDATA, 16'(16'hC000 + i));
            errors++;
         end
      end
   endtask

   task automatic test_reset_preserves();
      drive_cycle(1'b0, 8'hFF, 16'h0000);
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (RDATA !== 16'h0000) begin
         $display("FAIL preserve_async_clear: got %h expected %h", RDATA, 16'h0000);
         errors++;
      end
      @(negedge CLK);
      RST_N = 1'b1;
      drive_cycle(1'b0, 8'h7F, 16'h0000);
      checks++;
      if (RDATA !== 16'h007F) begin
         $display("FAIL preserve_contents: got %h expected %h", RDATA, 16'h007F);
         errors++;
      end
   endtask

   task automatic test_reset_during_write();
      @(negedge CLK);
      RST_N = 1'b0;
      WE    = 1'b1;
      ADDR  = 8'h30;
      WDATA = 16'h1234;
      @(posedge CLK);
      #1;
      checks++;
      if (RDATA !== 16'h0000) begin
         $display("FAIL rst_write_rdata: got %h expected %h", RDATA, 16'h0000);
         errors++;
      end
      @(negedge CLK);
      RST_N = 1'b1;
      WE    = 1'b0;
      drive_cycle(1'b0, 8'h30, 16'h0000);
      checks++;
      if (RDATA !== 16'h0030) begin
         $display("FAIL rst_write_dropped: got %h expected %h", RDATA, 16'h0030);
         errors++;
      end
   endtask

   initial begin
      RST_N = 1'b1;
      WE    = 1'b0;
      ADDR  = 8'h00;
      WDATA = 16'h0000;
      test_reset();
      test_sweep();
      test_write_inhibit();
      test_read_during_write();
      test_back_to_back();
      test_reset_preserves();
      test_reset_during_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_256_x16.md
# mem_256_x16

Single-port 256-word × 16-bit synchronous RAM for the 16-bit RISC computer. It serves as the CPU's combined program/data memory: the core presents an 8-bit word address, 16-bit write data and a write enable. Writes and reads both complete on the rising clock edge. Read data is registered and cleared by reset.

## Interface
Parameters:
- `DEPTH`, 256: number of words; fixed, matches 8-bit `ADDR`.
- `WIDTH`, 16: word width in bits.

Ports:
- `CLK`  input  1  system clock; all state changes on the rising edge.
- `RST_N`  input  1  reset, asynchronous, active-low.
- `WE`  input  1  write enable; 1 = write `WDATA` to `ADDR` at the rising edge.
- `ADDR`  input  8  word address, 0x00–0xFF.
- `WDATA`  input  16  write data.
- `RDATA`  output  16  registered read data.

## Operation
- Storage: array of 256 × 16-bit words. The array is not cleared by reset, so contents survive `RST_N` assertion.
- Write: at the rising `CLK` edge with `WE`=1 and `RST_N`=1, `mem[ADDR]` <= `WDATA`. With `WE`=0 the array is unchanged.
- Read: at every rising `CLK` edge with `RST_N`=1, `RDATA` <= `mem[ADDR]`, regardless of `WE`.
- Read-during-write (same edge, `WE`=1): the behaviour is selected by the macro in Configuration. The default is read-first, so `RDATA` takes the old contents of `mem[ADDR]`.
- Reset: while `RST_N`=0, `RDATA` = 16'h0000 immediately, without waiting for a clock edge. Writes are suppressed while `RST_N`=0.
- Addressing: the full 8-bit range is valid. There are no out-of-range or wrap cases; 0xFF is the last word.
- Uninitialised words read as X in simulation. Benches must write a location before checking it.

## Timing
- Write latency: 1 cycle. Data written at edge N is readable at edge N+1, so `RDATA` is valid after edge N+1.
- Read latency: 1 cycle. `ADDR` must be stable at edge N, and `RDATA` reflects `mem[ADDR]` after edge N. `RDATA` holds its value between edges.
- Inputs need only be stable around the rising edge. Driving them on the falling edge is supported.
- Reset assertion is asynchronous. Reset deassertion takes effect at the first rising edge where `RST_N`=1, and that edge performs a normal read/write.
- Reset asserted in the same cycle as a write: the write is dropped and `RDATA` = 0.
- Back-to-back writes to consecutive addresses, one per cycle, are supported with no stall.

## Configuration
- `MEM_256X16_WRITE_THROUGH_EN` defined: write-first. On an edge with `WE`=1, `RDATA` <= `WDATA`, so the new value appears in the same cycle it is written.
- Not defined (default): read-first. On an edge with `WE`=1, `RDATA` <= the previous `mem[ADDR]`.
- The array write is identical in both modes; only the `RDATA` source differs.

## Test plan
- Reset check: assert `RST_N`=0 mid-cycle, then release. `RDATA` must read 16'h0000 immediately on assertion and stay 0 until the first edge after release.
- Full sweep, write then read:
  - Write phase: `WE`=1; for i = 0..255 set `ADDR`=i, `WDATA`=i, one per cycle.
  - Read phase: `WE`=0; for i = 0..255 set `ADDR`=i. One cycle later `RDATA` must equal i (e.g. `ADDR`=0xFF gives 16'h00FF).
- Write inhibit: set `WE`=0, `ADDR`=0x10, `WDATA`=0xBEEF, run one cycle, then read 0x10. The result must be the prior value 0x0010.
- Read-during-write: with `mem[0x20]`=0x0020, write 0xA5A5 to 0x20. `RDATA` after that edge must be 0x0020 by default, or 0xA5A5 with `MEM_256X16_WRITE_THROUGH_EN`. The next read of 0x20 must give 0xA5A5 in both modes.
- Reset preserves contents: after the sweep, pulse `RST_N` low, then read 0x7F. The result must be 0x007F.
- Reset during write: `WE`=1, `ADDR`=0x30, `WDATA`=0x1234 with `RST_N`=0 across the edge. A later read of 0x30 must return the old value 0x0030.
